// File: rtl/multi_dataflow_in_buffer.sv
// multi_dataflow_in_buffer: job-framed input buffer between a streamer source
// and an engine sink. A start pulse latches the job length, the block accepts
// exactly that many words into a small registered FIFO, drains them downstream,
// then pulses done_o for one cycle.
module multi_dataflow_in_buffer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      clear_i,
    input  logic                      start_i,
    input  logic [31:0]               len_i,
    input  logic [DATA_WIDTH-1:0]     in_data_i,
    input  logic [DATA_WIDTH/8-1:0]   in_strb_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    output logic [DATA_WIDTH-1:0]     out_data_o,
    output logic [DATA_WIDTH/8-1:0]   out_strb_o,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic                      out_last_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [31:0]               cnt_o,
    output logic [$clog2(DEPTH):0]    occ_o
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned OW     = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [31:0]         r_len;
    logic [31:0]         r_in_cnt;
    logic [31:0]         r_cnt;
    logic [OW-1:0]       r_occ;
    logic [AW-1:0]       r_wptr;
    logic [AW-1:0]       r_rptr;
    logic [DATA_WIDTH-1:0] r_mem_data [DEPTH];
    logic [STRB_W-1:0]     r_mem_strb [DEPTH];

    logic                w_start;
    logic                w_push;
    logic                w_pop;
    logic                w_last_in;
    logic                w_last_out;

    // Handshake qualifiers; input side looks only at registered state so it
    // never depends on out_ready_i, and a full FIFO blocks even on a pop.
    assign w_start     = (r_state == S_IDLE) && start_i && !clear_i;
    assign in_ready_o  = (r_state == S_RUN) && (r_occ < OW'(DEPTH)) && (r_in_cnt < r_len);
    assign w_push      = in_valid_i && in_ready_o;
    assign out_valid_o = (r_occ != '0);
    assign w_pop       = out_valid_o && out_ready_i;
    assign w_last_in   = w_push && ((r_in_cnt + 32'd1) == r_len);
    assign w_last_out  = w_pop && ((r_cnt + 32'd1) == r_len);

    // Output decode from registered state and FIFO head.
    assign out_data_o = r_mem_data[r_rptr];
    assign out_strb_o = r_mem_strb[r_rptr];
    assign out_last_o = out_valid_o && (r_cnt == (r_len - 32'd1));
    assign busy_o     = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign done_o     = (r_state == S_DONE);
    assign cnt_o      = r_cnt;
    assign occ_o      = r_occ;

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; clear forces IDLE over any other transition.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_state_nxt = (len_i == 32'd0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_last_in) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_last_out) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (clear_i) begin
            w_state_nxt = S_IDLE;
        end
    end

    // Job length, word counters, FIFO pointers and occupancy.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_len    <= '0;
            r_in_cnt <= '0;
            r_cnt    <= '0;
            r_occ    <= '0;
            r_wptr   <= '0;
            r_rptr   <= '0;
        end else if (clear_i) begin
            r_len    <= '0;
            r_in_cnt <= '0;
            r_cnt    <= '0;
            r_occ    <= '0;
            r_wptr   <= '0;
            r_rptr   <= '0;
        end else begin
            if (w_start) begin
                r_len    <= len_i;
                r_in_cnt <= '0;
                r_cnt    <= '0;
            end else begin
                if (w_push) begin
                    r_in_cnt <= r_in_cnt + 32'd1;
                end
                if (w_pop) begin
                    r_cnt <= r_cnt + 32'd1;
                end
            end
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + OW'(1);
                2'b01:   r_occ <= r_occ - OW'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    // FIFO storage; contents are only meaningful where occupancy says so.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem_data[r_wptr] <= in_data_i;
            r_mem_strb[r_wptr] <= in_strb_i;
        end
    end

endmodule

// File: doc/multi_dataflow_in_buffer.md
MULTI_DATAFLOW_IN_BUFFER -- requirements
Module: multi_dataflow_in_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: stream data width in bits, multiple of 8.
REQ-002 SHALL have parameter DEPTH, default 4: FIFO entries, power of 2, >= 2.
REQ-003 SHALL have one clock, clk_i; reset is asynchronous and active-high, port rst_i.
REQ-004 SHALL have ports:
- clk_i  in  1  clock
- rst_i  in  1  async active-high reset
- clear_i  in  1  sync flush from ctrl
- start_i  in  1  job start pulse
- len_i  in  32  words in job, sampled on accepted start
- in_data_i  in  DATA_WIDTH  data from streamer inStream0 source
- in_strb_i  in  DATA_WIDTH/8  byte strobe
- in_valid_i  in  1  input valid
- in_ready_o  out  1  input ready
- out_data_o  out  DATA_WIDTH  data to engine inStream0 sink
- out_strb_o  out  DATA_WIDTH/8  strobe
- out_valid_o  out  1  output valid
- out_ready_i  in  1  output ready
- out_last_o  out  1  final word of job
- busy_o  out  1  job in progress
- done_o  out  1  one-cycle end-of-job pulse (event to ctrl)
- cnt_o  out  32  words delivered downstream this job
- occ_o  out  $clog2(DEPTH)+1  FIFO occupancy

Function
REQ-005 SHALL implement FSM IDLE, RUN, DRAIN, DONE.
REQ-006 IDLE: start_i=1 latches len_i; len_i=0 -> DONE, else -> RUN; in_cnt and cnt_o zeroed same edge.
REQ-007 start_i outside IDLE SHALL be ignored (no relatch, no state change).
REQ-008 Input handshake SHALL complete when in_valid_i && in_ready_o; in_ready_o = (state==RUN) && (occ_o<DEPTH) && (in_cnt<len).
REQ-009 in_ready_o SHALL NOT depend combinationally on out_ready_i; full FIFO blocks input even on a same-cycle pop.
REQ-010 RUN -> DRAIN on the edge in_cnt reaches len.
REQ-011 DRAIN -> DONE on the edge cnt_o reaches len (last word popped).
REQ-012 DONE SHALL last exactly one cycle with done_o=1, then -> IDLE.
REQ-013 FIFO SHALL be registered: word accepted at edge N visible on out_* no earlier than cycle after N (latency 1 when empty).
REQ-014 out_valid_o = (occ_o>0); out_data_o/out_strb_o SHALL be FIFO head, stable while out_valid_o && !out_ready_i.
REQ-015 Pop SHALL occur when out_valid_o && out_ready_i; cnt_o increments by 1 per pop.
REQ-016 Simultaneous push and pop SHALL leave occ_o unchanged and preserve order.
REQ-017 Read/write pointers SHALL wrap modulo DEPTH; occ_o SHALL range 0..DEPTH.
REQ-018 out_last_o SHALL equal out_valid_o && (cnt_o == len-1).
REQ-019 busy_o SHALL be 1 in RUN and DRAIN, 0 in IDLE and DONE.
REQ-020 Strobes SHALL pass unmodified; no reformatting of data.
REQ-021 clear_i SHALL, next edge, empty FIFO, zero counters and len, force IDLE, suppress done_o; clear_i overrides start_i.
REQ-022 in_cnt and cnt_o SHALL be 32-bit; len_i up to 2^32-1 supported without overflow.

Reset
REQ-023 rst_i=1 SHALL asynchronously force IDLE, occ_o=0, cnt_o=0, in_cnt=0, len=0, out_valid_o=0, in_ready_o=0, out_last_o=0, busy_o=0, done_o=0.
REQ-024 rst_i asserted mid-job SHALL discard buffered words; after release block waits in IDLE for new start_i.
REQ-025 FIFO storage SHALL need no reset; only control state.

Verification
REQ-026 start len=3, in_valid=1 data 0xA,0xB,0xC, out_ready=1 -> out 0xA,0xB,0xC in order, out_last only with 0xC, done_o one pulse one cycle after last pop, cnt_o=3.
REQ-027 DEPTH=4, len=8, out_ready=0 -> in_ready drops after 4 accepts, occ_o=4; out_ready=1 -> all 8 delivered, done_o once.
REQ-028 start len=0 -> next cycle done_o=1, busy_o never 1, no in_ready.
REQ-029 random in_valid/out_ready toggling, len=100 -> output equals input sequence, strobes intact, occ_o never >4 nor <0.
REQ-030 clear_i in DRAIN with occ_o=2 -> next cycle IDLE, occ_o=0, out_valid_o=0, no done_o; second start_i during RUN ignored.
REQ-031 rst_i asserted asynchronously mid-RUN -> outputs reach reset values before next clk_i edge.
